// File: rtl/mem_rr_arbiter_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory round-robin arbiter.
//   arb_state_e : top-level FSM states (INIT zero-fill, RUN arbitration)
//   rsp_pipe_t  : one response-pipe entry {valid, id, oor}
//   rr_pick()   : round-robin winner search, returns {found, idx}
// Widths are sized for the largest supported requester count (8) so the
// package stays parameter-free and usable by every instance.
package mem_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int ID_W     = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            oor;
    } rsp_pipe_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } rr_pick_t;

    // Scan requesters starting just after ptr, wrapping at nreq; the first
    // asserted request wins. Loop bound is the fixed maximum so the search
    // unrolls to constant hardware for any nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                         input logic [ID_W-1:0]     ptr,
                                         input int                  nreq);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = 1; i <= MAX_NREQ; i++) begin
            if (i <= nreq && !r.found) begin
                j = int'(ptr) + i;
                if (j >= nreq) j = j - nreq;
                if (req[j]) begin
                    r.found = 1'b1;
                    r.idx   = ID_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: client-side request/response bus of the arbiter.
//   req_valid/req_ready : per-requester handshake
//   req_we/addr/wdata   : per-requester command, slice i = requester i
//   rsp_valid           : per-requester read response strobe
//   rsp_data            : shared read data, qualified by rsp_valid
// master = requesters, slave = arbiter.
interface mem_rr_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_we;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_rr_arbiter_rr_arbiter.sv
// rr_arbiter: generic round-robin grant with a registered priority pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : grants allowed this cycle
//   req        : request vector
//   gnt        : one-hot (or zero) grant, combinational
//   gnt_idx    : index of the granted requester
//   gnt_found  : a grant is issued this cycle
// After reset the pointer sits at N-1, so requester 0 has first priority.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_found
);

    logic [ID_W-1:0]     ptr_q;
    logic [MAX_NREQ-1:0] req_ext;
    rr_pick_t            pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, ptr_q, N);
        gnt_found      = en && pick.found;
        gnt_idx        = pick.idx;
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_found && (pick.idx == ID_W'(i));
        end
    end

    // Pointer holds when nothing is granted so priority does not drift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(N - 1);
        end else if (gnt_found) begin
            ptr_q <= pick.idx;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one simple-dual-port RAM between NREQ requesters.
//   clk, rst_n   : clock, synchronous active-low reset
//   cl           : client bus (mem_rr_arbiter_if.slave)
//   err_addr     : one-cycle pulse after an accepted out-of-range request
//   init_done    : high once the post-reset zero-fill has finished
//   mem_wr_*     : RAM write port
//   mem_rd_*     : RAM read port, data returns RD_LATENCY cycles later
// After reset every location is written with zero, then one request per
// cycle is granted round-robin and issued straight to the RAM. Read
// responses are routed back to their issuer through a pipe that mirrors
// the RAM latency.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_rr_arbiter_if.slave       cl,
    output logic                  err_addr,
    output logic                  init_done,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;

    logic [NREQ-1:0]       gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_found;

    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_oor;

    rsp_pipe_t             rsp_p0;
    rsp_pipe_t             rsp_pipe_p [RD_LATENCY];
    rsp_pipe_t             rsp_tail;

    // Grants only in RUN; gating with rst_n keeps the pointer and all
    // memory enables quiet in the cycle a reset is being applied.
    rr_arbiter #(.N(NREQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (rst_n && (state_q == RUN)),
        .req       (cl.req_valid),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_found (gnt_found)
    );

    assign cl.req_ready = gnt;

    // Command mux: select the winner's slice.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_found && (gnt_idx == ID_W'(i))) begin
                win_we    = cl.req_we[i];
                win_addr  = cl.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = cl.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_oor = gnt_found && (33'(win_addr) >= 33'(DEPTH));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // FSM next state: the last fill write still happens before RUN.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == INIT) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    // FSM outputs and memory command drive
    always_comb begin
        init_done   = (state_q == RUN);
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        if (rst_n) begin
            if (state_q == INIT) begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = fill_q;
            end else if (gnt_found && !win_oor) begin
                if (win_we) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = win_addr;
                    mem_wr_data = win_wdata;
                end else begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = win_addr;
                end
            end
        end
    end

    // Stage p0: every granted read enters the pipe, including out-of-range
    // ones, so the requester always sees a response at the fixed latency.
    always_comb begin
        rsp_p0       = '0;
        rsp_p0.valid = gnt_found && !win_we;
        rsp_p0.id    = gnt_idx;
        rsp_p0.oor   = win_oor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) rsp_pipe_p[i] <= '0;
            err_addr <= 1'b0;
        end else begin
            rsp_pipe_p[0] <= rsp_p0;
            for (int i = 1; i < RD_LATENCY; i++) rsp_pipe_p[i] <= rsp_pipe_p[i-1];
            err_addr <= win_oor;
        end
    end

    // Pipe tail: route response; out-of-range reads return zero because
    // the RAM was never read and mem_rd_data is stale.
    assign rsp_tail = rsp_pipe_p[RD_LATENCY-1];

    always_comb begin
        cl.rsp_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            cl.rsp_valid[i] = rsp_tail.valid && (rsp_tail.id == ID_W'(i));
        end
        if (rsp_tail.valid && !rsp_tail.oor) begin
            cl.rsp_data = mem_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: bench for mem_rr_arbiter.
// dut_a: NREQ=2, DEPTH=16, RD_LATENCY=1 (fill, table, random, reset tests)
// dut_b: NREQ=2, DEPTH=16, RD_LATENCY=3 (latency sweep)
module tb_mem_rr_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DEP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_na, rst_nb;

    mem_rr_arbiter_if #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    mem_rr_arbiter_if #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    logic          a_err, a_done, a_wr_en, a_rd_en;
    logic [AW-1:0] a_wr_addr, a_rd_addr;
    logic [DW-1:0] a_wr_data, a_rd_data;
    logic          b_err, b_done, b_wr_en, b_rd_en;
    logic [AW-1:0] b_wr_addr, b_rd_addr;
    logic [DW-1:0] b_wr_data, b_rd_data;

    mem_rr_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .DEPTH(DEP), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_na), .cl(ifa.slave),
        .err_addr(a_err), .init_done(a_done),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data)
    );

    mem_rr_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .DEPTH(DEP), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_nb), .cl(ifb.slave),
        .err_addr(b_err), .init_done(b_done),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data)
    );

    // RAM models: write visible to a read in the following cycle.
    logic [DW-1:0] mema [256];
    logic [DW-1:0] a_rd_q;
    always @(posedge clk) begin
        if (a_rd_en) a_rd_q <= mema[a_rd_addr];
        if (a_wr_en) mema[a_wr_addr] <= a_wr_data;
    end
    assign a_rd_data = a_rd_q;

    logic [DW-1:0] memb [256];
    logic [DW-1:0] b_s0, b_s1, b_s2;
    always @(posedge clk) begin
        if (b_rd_en) b_s0 <= memb[b_rd_addr];
        b_s1 <= b_s0;
        b_s2 <= b_s1;
        if (b_wr_en) memb[b_wr_addr] <= b_wr_data;
    end
    assign b_rd_data = b_s2;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Requester-stability property on dut_a: an ungranted valid request
    // must be presented unchanged in the next cycle.
    logic          hv  [2];
    logic          hwe [2];
    logic [AW-1:0] ha  [2];
    logic [DW-1:0] hd  [2];

    task automatic hold_chk();
        for (int i = 0; i < 2; i++) begin
            if (rst_na && hv[i]) begin
                chk($sformatf("hold_req%0d", i),
                    {23'd0, ifa.req_valid[i], ifa.req_we[i],
                     ifa.req_addr[i*AW +: AW], ifa.req_wdata[i*DW +: DW]},
                    {23'd0, 1'b1, hwe[i], ha[i], hd[i]});
            end
            hv[i]  = rst_na && ifa.req_valid[i] && !ifa.req_ready[i];
            hwe[i] = ifa.req_we[i];
            ha[i]  = ifa.req_addr[i*AW +: AW];
            hd[i]  = ifa.req_wdata[i*DW +: DW];
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        hold_chk();
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifa.req_valid[i]          = v;
        ifa.req_we[i]             = we;
        ifa.req_addr[i*AW +: AW]  = a;
        ifa.req_wdata[i*DW +: DW] = d;
    endtask

    typedef struct {
        logic [1:0]    v;
        logic [1:0]    we;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    rdy;
        logic [1:0]    rv;
        logic [DW-1:0] rd;
        logic          err, wen, ren;
    } vec_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    vec_t          tbl [12];
    rsp_t          rq [$];
    logic [DW-1:0] mem_m [DEP];
    logic          pv  [2];
    logic          pwe [2];
    logic [AW-1:0] pa  [2];
    logic [DW-1:0] pd  [2];
    logic [DW-1:0] bvals [3];

    initial begin
        //            v     we    a0  a1  d0            d1  rdy   rv    rd            err wen ren
        tbl[0]  = '{2'b11, 2'b00, 3,  4,  0,            0,  2'b01, 2'b00, 0,            0, 0, 1};
        tbl[1]  = '{2'b11, 2'b00, 3,  4,  0,            0,  2'b10, 2'b01, 0,            0, 0, 1};
        tbl[2]  = '{2'b11, 2'b00, 3,  4,  0,            0,  2'b01, 2'b10, 0,            0, 0, 1};
        tbl[3]  = '{2'b10, 2'b00, 0,  4,  0,            0,  2'b10, 2'b01, 0,            0, 0, 1};
        tbl[4]  = '{2'b01, 2'b01, 5,  0,  32'hDEADBEEF, 0,  2'b01, 2'b10, 0,            0, 1, 0};
        tbl[5]  = '{2'b10, 2'b00, 0,  5,  0,            0,  2'b10, 2'b00, 0,            0, 0, 1};
        tbl[6]  = '{2'b00, 2'b00, 0,  0,  0,            0,  2'b00, 2'b10, 32'hDEADBEEF, 0, 0, 0};
        tbl[7]  = '{2'b01, 2'b01, 20, 0,  32'h12345678, 0,  2'b01, 2'b00, 0,            0, 0, 0};
        tbl[8]  = '{2'b01, 2'b00, 5,  0,  0,            0,  2'b01, 2'b00, 0,            1, 0, 1};
        tbl[9]  = '{2'b01, 2'b00, 20, 0,  0,            0,  2'b01, 2'b01, 32'hDEADBEEF, 0, 0, 0};
        tbl[10] = '{2'b00, 2'b00, 0,  0,  0,            0,  2'b00, 2'b01, 0,            1, 0, 0};
        tbl[11] = '{2'b00, 2'b00, 0,  0,  0,            0,  2'b00, 2'b00, 0,            0, 0, 0};

        for (int i = 0; i < 2; i++) begin
            hv[i] = 1'b0; hwe[i] = 1'b0; ha[i] = '0; hd[i] = '0;
        end

        // Reset state; requesters already waiting for the fill to end.
        rst_na = 1'b0;
        rst_nb = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'd3, '0);
        set_req(1, 1'b1, 1'b0, 8'd4, '0);
        ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            pedge();
            nedge();
            chk("rst_init_done", 64'(a_done), 0);
            chk("rst_rsp_valid", 64'(ifa.rsp_valid), 0);
            chk("rst_rsp_data", 64'(ifa.rsp_data), 0);
            chk("rst_err_addr", 64'(a_err), 0);
            chk("rst_mem_en", {62'd0, a_wr_en, a_rd_en}, 0);
            chk("rst_req_ready", 64'(ifa.req_ready), 0);
        end
        pedge();
        rst_na = 1'b1;
        rst_nb = 1'b1;

        // Zero-fill: 16 writes of zero to addresses 0..15, no grants.
        for (int k = 0; k < DEP; k++) begin
            nedge();
            chk("fill_wr_en", 64'(a_wr_en), 1);
            chk("fill_wr_addr", 64'(a_wr_addr), 64'(k));
            chk("fill_wr_data", 64'(a_wr_data), 0);
            chk("fill_rd_en", 64'(a_rd_en), 0);
            chk("fill_req_ready", 64'(ifa.req_ready), 0);
            chk("fill_init_done", 64'(a_done), 0);
            pedge();
        end

        // Table: round-robin, write-then-read, out-of-range.
        for (int r = 0; r < 12; r++) begin
            set_req(0, tbl[r].v[0], tbl[r].we[0], tbl[r].a0, tbl[r].d0);
            set_req(1, tbl[r].v[1], tbl[r].we[1], tbl[r].a1, tbl[r].d1);
            nedge();
            chk($sformatf("tbl%0d_init_done", r), 64'(a_done), 1);
            chk($sformatf("tbl%0d_req_ready", r), 64'(ifa.req_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d_rsp_valid", r), 64'(ifa.rsp_valid), 64'(tbl[r].rv));
            chk($sformatf("tbl%0d_rsp_data", r), 64'(ifa.rsp_data), 64'(tbl[r].rd));
            chk($sformatf("tbl%0d_err_addr", r), 64'(a_err), 64'(tbl[r].err));
            chk($sformatf("tbl%0d_mem_en", r), {62'd0, a_wr_en, a_rd_en},
                {62'd0, tbl[r].wen, tbl[r].ren});
            pedge();
        end

        // Random traffic against a scoreboard. Last grant above was to
        // requester 0; memory holds zeros except address 5.
        begin
            int ptr_m;
            int win;
            logic err_exp;
            logic [1:0] rv_exp;
            logic [DW-1:0] rd_exp;
            ptr_m = 0;
            err_exp = 1'b0;
            for (int i = 0; i < DEP; i++) mem_m[i] = '0;
            mem_m[5] = 32'hDEADBEEF;
            for (int i = 0; i < 2; i++) begin
                pv[i] = 1'b0; pwe[i] = 1'b0; pa[i] = '0; pd[i] = '0;
            end
            for (int c = 0; c < 300; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pv[i] && ($urandom_range(0, 9) < 7)) begin
                        pv[i]  = 1'b1;
                        pwe[i] = 1'($urandom_range(0, 1));
                        pa[i]  = AW'($urandom_range(0, 19));
                        pd[i]  = $urandom;
                    end
                    set_req(i, pv[i], pwe[i], pa[i], pd[i]);
                end
                nedge();
                win = -1;
                for (int k = 1; k <= 2; k++) begin
                    if (win < 0 && pv[(ptr_m + k) % 2]) win = (ptr_m + k) % 2;
                end
                chk("rnd_req_ready", 64'(ifa.req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
                rv_exp = 2'b00;
                rd_exp = '0;
                if (rq.size() > 0 && rq[0].due == c) begin
                    rv_exp = 2'(1 << rq[0].id);
                    rd_exp = rq[0].data;
                    void'(rq.pop_front());
                end
                chk("rnd_rsp_valid", 64'(ifa.rsp_valid), 64'(rv_exp));
                chk("rnd_rsp_data", 64'(ifa.rsp_data), 64'(rd_exp));
                chk("rnd_err_addr", 64'(a_err), 64'(err_exp));
                err_exp = 1'b0;
                if (win >= 0) begin
                    ptr_m = win;
                    err_exp = (pa[win] >= AW'(DEP));
                    if (pwe[win]) begin
                        if (pa[win] < AW'(DEP)) mem_m[pa[win][3:0]] = pd[win];
                    end else begin
                        rq.push_back('{c + 1, win,
                                       (pa[win] < AW'(DEP)) ? mem_m[pa[win][3:0]] : '0});
                    end
                    pv[win] = 1'b0;
                end
                pedge();
            end
        end

        // Reset mid-fill: fill restarts at address 0.
        rst_na = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        nedge();
        chk("rst2_mem_en", {62'd0, a_wr_en, a_rd_en}, 0);
        chk("rst2_req_ready", 64'(ifa.req_ready), 0);
        pedge();
        nedge();
        chk("rst2_init_done", 64'(a_done), 0);
        chk("rst2_rsp_valid", 64'(ifa.rsp_valid), 0);
        chk("rst2_err_addr", 64'(a_err), 0);
        pedge();
        rst_na = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nedge();
            chk("part_wr_addr", {55'd0, a_wr_en, a_wr_addr}, {55'd0, 1'b1, AW'(k)});
            pedge();
        end
        rst_na = 1'b0;
        nedge();
        chk("midfill_wr_en", 64'(a_wr_en), 0);
        pedge();
        rst_na = 1'b1;
        for (int k = 0; k < DEP; k++) begin
            nedge();
            chk("refill_wr_addr", {55'd0, a_wr_en, a_wr_addr}, {55'd0, 1'b1, AW'(k)});
            chk("refill_init_done", 64'(a_done), 0);
            pedge();
        end
        nedge();
        chk("refill_done", 64'(a_done), 1);
        pedge();

        // Latency sweep on dut_b (RD_LATENCY=3).
        bvals[0] = 32'h1111_0001;
        bvals[1] = 32'h2222_0002;
        bvals[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin
            ifb.req_valid = 2'b01;
            ifb.req_we    = 2'b01;
            ifb.req_addr  = {8'd0, 8'(i + 1)};
            ifb.req_wdata = {32'd0, bvals[i]};
            nedge();
            chk("lat_init_done", 64'(b_done), 1);
            chk("lat_wr_ready", 64'(ifb.req_ready), 1);
            chk("lat_wr_en", {55'd0, b_wr_en, b_wr_addr}, {55'd0, 1'b1, AW'(i + 1)});
            pedge();
        end
        for (int c = 0; c < 8; c++) begin
            ifb.req_valid = (c < 3) ? 2'b01 : 2'b00;
            ifb.req_we    = 2'b00;
            ifb.req_addr  = {8'd0, 8'(c + 1)};
            ifb.req_wdata = '0;
            nedge();
            chk("lat_ready", 64'(ifb.req_ready), (c < 3) ? 64'd1 : 64'd0);
            chk("lat_rsp_valid", 64'(ifb.rsp_valid), (c >= 3 && c < 6) ? 64'd1 : 64'd0);
            chk("lat_rsp_data", 64'(ifb.rsp_data),
                (c >= 3 && c < 6) ? 64'(bvals[c - 3]) : 64'd0);
            chk("lat_err_addr", 64'(b_err), 0);
            pedge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one simple-dual-port RAM (one write port, one read port, synchronous read) between NREQ requesters, using round-robin arbitration.
- After reset, runs a zero-fill sequence over every address. Once that finishes, it accepts one request per cycle.
- Returns read data to the requester that issued the read, after the fixed RAM latency.
- Sits between the client interfaces and the memory macro. The memory's shadow-model checker attaches to the memory-side ports.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, address width.
- DATA_WIDTH, 32, data width.
- DEPTH, 256, number of valid locations (≤ 2**ADDR_WIDTH).
- RD_LATENCY, 1, RAM cycles from mem_rd_en to mem_rd_data valid (1..4).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_WIDTH  address; slice i belongs to requester i.
- req_wdata  in  NREQ*DATA_WIDTH  write data; slice i belongs to requester i.
- rsp_valid  out  NREQ  read data valid for requester i.
- rsp_data  out  DATA_WIDTH  read data, shared bus, qualified by rsp_valid.
- err_addr  out  1  one-cycle pulse: an accepted request had addr ≥ DEPTH.
- init_done  out  1  high once zero-fill completes.
- mem_wr_en, mem_wr_addr, mem_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port.
- mem_rd_en, mem_rd_addr  out  1/ADDR_WIDTH  RAM read port.
- mem_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after mem_rd_en.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=INIT, init counter=0, rr pointer=NREQ-1 (requester 0 has highest priority first).
  - Response pipe cleared.
  - Reset values: init_done=0, rsp_valid=0, rsp_data=0, err_addr=0.
  - Memory enables are 0 while rst_n=0.
- FSM INIT:
  - Each cycle drives mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=0. Counter increments.
  - On counter==DEPTH-1 the write still occurs, then state→RUN and init_done=1 registered (first high the cycle after the last write). Fill takes exactly DEPTH cycles.
  - req_ready=0 throughout INIT.
  - Reset asserted mid-INIT restarts the fill at address 0.
- FSM RUN:
  - init_done stays 1 until reset. No return to INIT.
- Arbitration (RUN only, combinational grant):
  - Scan from (ptr+1) mod NREQ upward; the first requester with req_valid wins.
  - req_ready[winner]=1 in the same cycle. At most one grant per cycle.
  - ptr←winner on grant. ptr is unchanged if there is no request.
- Command issue:
  - Memory outputs are driven combinationally from the winner in the same cycle.
  - Winning write: mem_wr_en=1, mem_rd_en=0.
  - Winning read: mem_rd_en=1, mem_wr_en=0.
- Out-of-range address (addr ≥ DEPTH):
  - The request is still granted. No memory enable is asserted.
  - err_addr pulses 1 on the next cycle (registered).
  - A read with an out-of-range address still produces a response, with rsp_data=0, at normal latency.
- Response pipe:
  - Shift register of depth RD_LATENCY carrying {valid, id, oor}.
  - At the output stage: rsp_valid[id]=1 and rsp_data=mem_rd_data, or 0 if oor. Both are combinational from the pipe tail.
  - rsp_data=0 when no response is valid.
  - Requesters must always accept responses; there is no backpressure.
- Same-address hazard:
  - A write granted in cycle N followed by a read of the same address in cycle N+1 must return the new data. The RAM is write-then-readable next cycle; the arbiter adds no bypass.
  - A read and a write cannot occur in the same cycle (single grant).
- Requester obligation:
  - req_valid, req_we, req_addr and req_wdata are held stable until req_ready.
  - The bench asserts this property; the RTL does not check it.
- Fairness:
  - With all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_e {INIT, RUN}.
  - Struct rsp_pipe_t {valid, id[$clog2(NREQ)], oor}.
  - Function rr_pick(req, ptr) returning winner index plus a found flag.
- One sub-module, rr_arbiter: pure round-robin grant with registered pointer. It is reusable for other shared resources.
- The top level holds the FSM, the command mux and the response pipe.

Test Plan:
- Zero-fill (DEPTH=16): release reset with req_valid=2'b11 → mem_wr_en high for 16 cycles, addrs 0..15, data 0; req_ready=0 throughout; init_done=1 on cycle 17; first grant to requester 0.
- Round-robin: both requesters hold reads continuously → req_ready alternates 01,10,01,10; rsp_valid follows the same pattern delayed by RD_LATENCY.
- Write-then-read: req0 writes addr 5 = 0xDEADBEEF, next cycle req1 reads addr 5 → rsp_valid=2'b10 with rsp_data=0xDEADBEEF after 1 cycle (RD_LATENCY=1).
- Out-of-range: DEPTH=16, req0 writes addr 20 → no mem_wr_en, err_addr pulses the next cycle; req0 reads addr 20 → rsp_data=0 with rsp_valid[0]=1, err_addr pulses.
- Reset mid-INIT: assert rst_n=0 at fill addr 7 → after release, fill restarts at addr 0 and init_done stays low until 16 further cycles.
- Latency sweep: RD_LATENCY=3, back-to-back reads from req0 to addrs 1,2,3 → three responses in order on consecutive cycles, 3 cycles after each grant.
